// File: rtl/rot_share_ctrl_pkg.sv
// rot_pkg: types and constants shared by the rot_share_ctrl slice.
//   rot_op_e     : shift/rotate op codes carried on inX_op (5-7 are illegal)
//   out_state_e  : occupancy of the registered output stage
//   ROT_W        : datapath width
//   ROT_AMT_W    : width of the shift/rotate amount
package rot_pkg;

  localparam int unsigned ROT_W     = 16;
  localparam int unsigned ROT_AMT_W = 4;

  typedef enum logic [2:0] {
    OP_ROR = 3'd0,
    OP_ROL = 3'd1,
    OP_LSR = 3'd2,
    OP_LSL = 3'd3,
    OP_ASR = 3'd4
  } rot_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rot_share_ctrl_if.sv
// rot_share_ctrl_if: the two requester channels and the result channel.
//   in0_* / in1_*  : valid/ready request channels (op, data, amt payload)
//   out_*          : valid/ready result channel with winner id and Z/N/C/V
// Modports:
//   master : requesters and result consumer (testbench / surrounding pipeline)
//   slave  : rot_share_ctrl
interface rot_share_ctrl_if;
  import rot_pkg::*;

  logic                 in0_valid;
  logic                 in0_ready;
  logic [2:0]           in0_op;
  logic [ROT_W-1:0]     in0_data;
  logic [ROT_AMT_W-1:0] in0_amt;

  logic                 in1_valid;
  logic                 in1_ready;
  logic [2:0]           in1_op;
  logic [ROT_W-1:0]     in1_data;
  logic [ROT_AMT_W-1:0] in1_amt;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_id;
  logic [ROT_W-1:0]     out_result;
  logic                 out_z;
  logic                 out_n;
  logic                 out_c;
  logic                 out_v;

  modport master (
    output in0_valid, in0_op, in0_data, in0_amt,
    input  in0_ready,
    output in1_valid, in1_op, in1_data, in1_amt,
    input  in1_ready,
    input  out_valid, out_id, out_result, out_z, out_n, out_c, out_v,
    output out_ready
  );

  modport slave (
    input  in0_valid, in0_op, in0_data, in0_amt,
    output in0_ready,
    input  in1_valid, in1_op, in1_data, in1_amt,
    output in1_ready,
    output out_valid, out_id, out_result, out_z, out_n, out_c, out_v,
    input  out_ready
  );

endinterface

// File: rtl/rot_op_decode.sv
// rot_rotr: 16-bit combinational rotate-right.
//   data in, k (rotate amount) in, rot out.
// rot_op_decode: maps ROR/ROL/LSR/LSL/ASR onto one rot_rotr instance.
//   op, data, amt in; k, rot (raw rotator output), mask (bits to be forced),
//   fill (value of the forced bits), c and v out.
module rot_rotr
  import rot_pkg::*;
(
  input  logic [ROT_W-1:0]     data,
  input  logic [ROT_AMT_W-1:0] k,
  output logic [ROT_W-1:0]     rot
);

  logic [2*ROT_W-1:0] dbl;

  // Rotating the doubled word right leaves the rotation in the low half.
  always_comb begin
    dbl = {data, data} >> k;
    rot = dbl[ROT_W-1:0];
  end

endmodule

module rot_op_decode
  import rot_pkg::*;
(
  input  logic [2:0]           op,
  input  logic [ROT_W-1:0]     data,
  input  logic [ROT_AMT_W-1:0] amt,
  output logic [ROT_AMT_W-1:0] k,
  output logic [ROT_W-1:0]     rot,
  output logic [ROT_W-1:0]     mask,
  output logic                 fill,
  output logic                 c,
  output logic                 v
);

  logic [ROT_AMT_W-1:0] neg_amt;
  logic [ROT_AMT_W-1:0] low_idx;
  logic [ROT_W-1:0]     ones;
  logic                 amt_nz;

  always_comb begin
    ones    = '1;
    // (16 - a) & 15 falls out of 4-bit wrap-around negation.
    neg_amt = ROT_AMT_W'(0) - amt;
    low_idx = amt - ROT_AMT_W'(1);
    amt_nz  = (amt != '0);

    k    = '0;
    mask = '0;
    fill = 1'b0;
    c    = 1'b0;
    v    = 1'b0;

    case (op)
      OP_ROR: k = amt;
      OP_ROL: k = neg_amt;
      OP_LSR: begin
        k    = amt;
        mask = ~(ones >> amt);
        c    = amt_nz ? data[low_idx] : 1'b0;
      end
      OP_LSL: begin
        k    = neg_amt;
        mask = ~(ones << amt);
        c    = amt_nz ? data[neg_amt] : 1'b0;
      end
      OP_ASR: begin
        k    = amt;
        mask = ~(ones >> amt);
        fill = data[ROT_W-1];
        c    = amt_nz ? data[low_idx] : 1'b0;
      end
      default: v = 1'b1;
    endcase
  end

  rot_rotr u_rotr (
    .data (data),
    .k    (k),
    .rot  (rot)
  );

endmodule

// File: rtl/rot_share_ctrl.sv
// rot_share_ctrl: round-robin sharing of one rotator between two requesters,
// with a registered, flagged result on a single valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave modport) : in0_*/in1_* request channels, out_* result channel
//   stat0_cnt/stat1_cnt : per-port accepted-grant counters
// Optional feature macro ROT_STATS_EN: when defined, the grant counters are
// built; otherwise both stat outputs are tied to zero.
module rot_share_ctrl
  import rot_pkg::*;
#(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rot_share_ctrl_if.slave   bus,
  output logic [STAT_W-1:0] stat0_cnt,
  output logic [STAT_W-1:0] stat1_cnt
);

  out_state_e state_q, state_d;

  logic                 last_grant_q;
  logic                 gnt0, gnt1, win, any_valid;
  logic                 can_accept, accept;

  logic [2:0]           sel_op;
  logic [ROT_W-1:0]     sel_data;
  logic [ROT_AMT_W-1:0] sel_amt;

  logic [ROT_AMT_W-1:0] dec_k;
  logic [ROT_W-1:0]     dec_rot, dec_mask;
  logic                 dec_fill, dec_c, dec_v;
  logic [ROT_W-1:0]     result;

  logic                 id_q;
  logic [ROT_W-1:0]     result_q;
  logic                 z_q, n_q, c_q, v_q;

  // Arbitration: on a tie the port that did not win last time goes.
  always_comb begin
    gnt0       = bus.in0_valid && (!bus.in1_valid || last_grant_q);
    gnt1       = bus.in1_valid && (!bus.in0_valid || !last_grant_q);
    win        = gnt1;
    any_valid  = bus.in0_valid || bus.in1_valid;
    can_accept = (state_q == ST_EMPTY) || bus.out_ready;
    accept     = any_valid && can_accept;

    sel_op     = win ? bus.in1_op   : bus.in0_op;
    sel_data   = win ? bus.in1_data : bus.in0_data;
    sel_amt    = win ? bus.in1_amt  : bus.in0_amt;
  end

  rot_op_decode u_decode (
    .op   (sel_op),
    .data (sel_data),
    .amt  (sel_amt),
    .k    (dec_k),
    .rot  (dec_rot),
    .mask (dec_mask),
    .fill (dec_fill),
    .c    (dec_c),
    .v    (dec_v)
  );

  always_comb begin
    result = (dec_rot & ~dec_mask) | (dec_mask & {ROT_W{dec_fill}});
  end

  // Output-stage FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Output-stage FSM: next state. A drain and refill in one cycle stays FULL.
  always_comb begin
    state_d = state_q;
    if (accept)             state_d = ST_FULL;
    else if (bus.out_ready) state_d = ST_EMPTY;
  end

  // Output-stage FSM: outputs.
  always_comb begin
    bus.out_valid = (state_q == ST_FULL);
    bus.in0_ready = gnt0 && can_accept;
    bus.in1_ready = gnt1 && can_accept;
  end

  // Result register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      result_q     <= '0;
      z_q          <= 1'b0;
      n_q          <= 1'b0;
      c_q          <= 1'b0;
      v_q          <= 1'b0;
    end else if (accept) begin
      last_grant_q <= win;
      id_q         <= win;
      result_q     <= result;
      z_q          <= (result == '0);
      n_q          <= result[ROT_W-1];
      c_q          <= dec_c;
      v_q          <= dec_v;
    end
  end

  always_comb begin
    bus.out_id     = id_q;
    bus.out_result = result_q;
    bus.out_z      = z_q;
    bus.out_n      = n_q;
    bus.out_c      = c_q;
    bus.out_v      = v_q;
  end

`ifdef ROT_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (win) cnt1_q <= cnt1_q + STAT_W'(1);
      else     cnt0_q <= cnt0_q + STAT_W'(1);
    end
  end

  always_comb begin
    stat0_cnt = cnt0_q;
    stat1_cnt = cnt1_q;
  end
`else
  always_comb begin
    stat0_cnt = '0;
    stat1_cnt = '0;
  end
`endif

endmodule

// File: tb/tb_rot_share_ctrl.sv
// Directed testbench for rot_share_ctrl.
module tb_rot_share_ctrl;
  import rot_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] stat0_cnt, stat1_cnt;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  rot_share_ctrl_if bus ();

  rot_share_ctrl #(.STAT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stat0_cnt (stat0_cnt),
    .stat1_cnt (stat1_cnt)
  );

  // Present one op on a port and wait (bounded) for it to be accepted.
  // Returns at accept edge + 1, with the port's valid dropped.
  task automatic issue(input bit port, input logic [2:0] op,
                       input logic [15:0] data, input logic [3:0] amt);
    bit done = 1'b0;
    @(negedge clk);
    if (!port) begin
      bus.in0_valid = 1'b1; bus.in0_op = op; bus.in0_data = data; bus.in0_amt = amt;
    end else begin
      bus.in1_valid = 1'b1; bus.in1_op = op; bus.in1_data = data; bus.in1_amt = amt;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if ((!port && bus.in0_ready) || (port && bus.in1_ready)) begin
        @(posedge clk); #1; done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!port) bus.in0_valid = 1'b0;
    else       bus.in1_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL issue_timeout port=%0d op=%0d got=not_accepted exp=accepted", port, op);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in0_valid = 1'b0; bus.in0_op = '0; bus.in0_data = '0; bus.in0_amt = '0;
    bus.in1_valid = 1'b0; bus.in1_op = '0; bus.in1_data = '0; bus.in1_amt = '0;
    bus.out_ready = 1'b0;
    #12;
    checks++;
    if ({bus.out_valid, bus.out_id} !== 2'b00) begin
      failures++; $display("FAIL reset_valid_id got=%b exp=00", {bus.out_valid, bus.out_id});
    end
    checks++;
    if (bus.out_result !== 16'h0000) begin
      failures++; $display("FAIL reset_result got=%h exp=0000", bus.out_result);
    end
    checks++;
    if ({bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
    checks++;
    if ({stat0_cnt, stat1_cnt} !== 32'h0) begin
      failures++; $display("FAIL reset_stats got=%h exp=00000000", {stat0_cnt, stat1_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ror();
    bus.out_ready = 1'b1;
    issue(1'b0, 3'd0, 16'h8001, 4'd1);
    checks++;
    if (bus.out_result !== 16'hC000) begin
      failures++; $display("FAIL ror_result got=%h exp=C000", bus.out_result);
    end
    checks++;
    if ({bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== 4'b0100) begin
      failures++; $display("FAIL ror_flags got=%b exp=0100", {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
    checks++;
    if ({bus.out_valid, bus.out_id} !== 2'b10) begin
      failures++; $display("FAIL ror_valid_id got=%b exp=10", {bus.out_valid, bus.out_id});
    end
  endtask

  task automatic test_rol_lsr_lsl();
    issue(1'b0, 3'd1, 16'h8001, 4'd4);
    checks++;
    if ({bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== {16'h0018, 4'b0000}) begin
      failures++; $display("FAIL rol got=%h/%b exp=0018/0000", bus.out_result, {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
    issue(1'b0, 3'd2, 16'h0003, 4'd1);
    checks++;
    if ({bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== {16'h0001, 4'b0010}) begin
      failures++; $display("FAIL lsr got=%h/%b exp=0001/0010", bus.out_result, {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
    issue(1'b0, 3'd3, 16'h8000, 4'd1);
    checks++;
    if ({bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== {16'h0000, 4'b1010}) begin
      failures++; $display("FAIL lsl got=%h/%b exp=0000/1010", bus.out_result, {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
    issue(1'b0, 3'd3, 16'h0003, 4'd15);
    checks++;
    if ({bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== {16'h8000, 4'b0110}) begin
      failures++; $display("FAIL lsl15 got=%h/%b exp=8000/0110", bus.out_result, {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
  endtask

  task automatic test_asr_illegal();
    issue(1'b1, 3'd2, 16'hA5A5, 4'd0);
    checks++;
    if ({bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== {16'hA5A5, 4'b0100}) begin
      failures++; $display("FAIL lsr_amt0 got=%h/%b exp=A5A5/0100", bus.out_result, {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
    checks++;
    if (bus.out_id !== 1'b1) begin
      failures++; $display("FAIL lsr_amt0_id got=%b exp=1", bus.out_id);
    end
    issue(1'b0, 3'd4, 16'h8000, 4'd15);
    checks++;
    if ({bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== {16'hFFFF, 4'b0100}) begin
      failures++; $display("FAIL asr got=%h/%b exp=FFFF/0100", bus.out_result, {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
    issue(1'b0, 3'd6, 16'h1234, 4'd3);
    checks++;
    if ({bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== {16'h1234, 4'b0001}) begin
      failures++; $display("FAIL illegal got=%h/%b exp=1234/0001", bus.out_result, {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
    checks++;
    if (bus.out_id !== 1'b0) begin
      failures++; $display("FAIL illegal_id got=%b exp=0", bus.out_id);
    end
  endtask

  task automatic test_contention();
    logic [15:0] exp_res;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in0_valid = 1'b1; bus.in0_op = 3'd0; bus.in0_data = 16'h1111; bus.in0_amt = 4'd0;
    bus.in1_valid = 1'b1; bus.in1_op = 3'd0; bus.in1_data = 16'h2222; bus.in1_amt = 4'd0;
    #1;
    checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      failures++; $display("FAIL contention_first_ready got=%b exp=10", {bus.in0_ready, bus.in1_ready});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_res = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      checks++;
      if ({bus.out_valid, bus.out_id, bus.out_result} !== {1'b1, 1'(i % 2), exp_res}) begin
        failures++;
        $display("FAIL contention_%0d got=v%b id%b %h exp=v1 id%0d %h",
                 i, bus.out_valid, bus.out_id, bus.out_result, i % 2, exp_res);
      end
    end
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    issue(1'b0, 3'd0, 16'h00F0, 4'd4);
    bus.out_ready = 1'b0;
    bus.in0_valid = 1'b1; bus.in0_op = 3'd2; bus.in0_data = 16'hFFFF; bus.in0_amt = 4'd8;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== {1'b1, 16'h000F, 4'b0000}) begin
        failures++;
        $display("FAIL hold_%0d got=v%b %h/%b exp=v1 000F/0000", i, bus.out_valid, bus.out_result,
                 {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
      end
      checks++;
      if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
        failures++; $display("FAIL hold_ready_%0d got=%b exp=00", i, {bus.in0_ready, bus.in1_ready});
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if ({bus.in0_ready, bus.out_valid} !== 2'b11) begin
      failures++; $display("FAIL refill_ready got=%b exp=11", {bus.in0_ready, bus.out_valid});
    end
    @(posedge clk); #1;
    bus.in0_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v} !== {1'b1, 16'h00FF, 4'b0010}) begin
      failures++;
      $display("FAIL refill got=v%b %h/%b exp=v1 00FF/0010", bus.out_valid, bus.out_result,
               {bus.out_z, bus.out_n, bus.out_c, bus.out_v});
    end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    @(negedge clk);
    #2;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL pre_reset_full got=%b exp=1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_id, bus.out_result} !== 18'h0) begin
      failures++; $display("FAIL midreset_out got=v%b id%b %h exp=v0 id0 0000",
                           bus.out_valid, bus.out_id, bus.out_result);
    end
    checks++;
    if ({bus.out_z, bus.out_n, bus.out_c, bus.out_v, stat0_cnt, stat1_cnt} !== 36'h0) begin
      failures++; $display("FAIL midreset_flags_stats got=%b %h %h exp=0000 0000 0000",
                           {bus.out_z, bus.out_n, bus.out_c, bus.out_v}, stat0_cnt, stat1_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in0_valid = 1'b1; bus.in0_op = 3'd0; bus.in0_data = 16'h0F0F; bus.in0_amt = 4'd4;
    bus.in1_valid = 1'b1; bus.in1_op = 3'd0; bus.in1_data = 16'h3333; bus.in1_amt = 4'd0;
    @(posedge clk); #1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_id, bus.out_result} !== {1'b1, 1'b0, 16'hF0F0}) begin
      failures++; $display("FAIL post_reset_grant got=v%b id%b %h exp=v1 id0 F0F0",
                           bus.out_valid, bus.out_id, bus.out_result);
    end
  endtask

  initial begin
    test_reset();
    test_ror();
    test_rol_lsr_lsl();
    test_asr_illegal();
    test_contention();
    test_back_to_back();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
